// File: rtl/lift_req_conditioner.sv
// Conditions raw lift pushbuttons and sensors: 2-flop sync, per-input debounce,
// press-edge detection and mutually exclusive up/down request latches.
module lift_req_conditioner #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic up_raw,
    input  logic down_raw,
    input  logic door_raw,
    input  logic top_raw,
    input  logic ground_raw,
    output logic up_button,
    output logic down_button,
    output logic doors_closed,
    output logic top_floor,
    output logic ground_floor,
    output logic sensor_fault
);

    localparam int N = 5;
    localparam int UP = 0, DN = 1, DOOR = 2, TOP = 3, GND = 4;

    logic [N-1:0] raw;
    logic [N-1:0] sync1_q, sync2_q;
    logic [N-1:0] filt_q, filt_d;
    logic [7:0]   cnt_q [N];
    logic [7:0]   cnt_d [N];
    logic [1:0]   prev_q, prev_d;
    logic         up_req_q, up_req_d;
    logic         down_req_q, down_req_d;
    logic         fault_q, fault_d;

    logic up_press, down_press, up_set, down_set, both_high;

    assign raw = {ground_raw, top_raw, door_raw, down_raw, up_raw};

    // Counter runs only while the synchronized input disagrees; it flips the filter on its last count.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = 8'd0;
            if (sync2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == 8'(DB_CYCLES - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        prev_d     = filt_q[DN:UP];
        up_press   = filt_q[UP] & ~prev_q[UP];
        down_press = filt_q[DN] & ~prev_q[DN];
        both_high  = filt_q[TOP] & filt_q[GND];
        fault_d    = fault_q | both_high;

        up_set   = up_press & ~filt_q[TOP] & ~down_req_q & ~fault_q;
        down_set = down_press & ~filt_q[GND] & ~up_req_q & ~fault_q & ~up_set;

        // Clearing (floor reached or fault) takes priority over a new press.
        up_req_d = up_req_q;
        if (both_high || fault_q || filt_q[TOP]) begin
            up_req_d = 1'b0;
        end else if (up_set) begin
            up_req_d = 1'b1;
        end

        down_req_d = down_req_q;
        if (both_high || fault_q || filt_q[GND]) begin
            down_req_d = 1'b0;
        end else if (down_set) begin
            down_req_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            filt_q     <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= 8'd0;
            end
            prev_q     <= '0;
            up_req_q   <= 1'b0;
            down_req_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            filt_q     <= filt_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            prev_q     <= prev_d;
            up_req_q   <= up_req_d;
            down_req_q <= down_req_d;
            fault_q    <= fault_d;
        end
    end

    assign up_button    = up_req_q;
    assign down_button  = down_req_q;
    assign doors_closed = filt_q[DOOR];
    assign top_floor    = filt_q[TOP] & ~fault_q;
    assign ground_floor = filt_q[GND] & ~fault_q;
    assign sensor_fault = fault_q;

endmodule

// File: tb/tb_lift_req_conditioner.sv
// Directed bench for lift_req_conditioner at DB_CYCLES=4; outputs are checked
// as the vector {up_button, down_button, doors_closed, top_floor, ground_floor, sensor_fault}.
module tb_lift_req_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic up_raw = 1'b0, down_raw = 1'b0, door_raw = 1'b0, top_raw = 1'b0, ground_raw = 1'b0;
    logic up_button, down_button, doors_closed, top_floor, ground_floor, sensor_fault;
    logic [5:0] outs;

    int checks = 0;
    int passes = 0;

    lift_req_conditioner #(.DB_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .up_raw       (up_raw),
        .down_raw     (down_raw),
        .door_raw     (door_raw),
        .top_raw      (top_raw),
        .ground_raw   (ground_raw),
        .up_button    (up_button),
        .down_button  (down_button),
        .doors_closed (doors_closed),
        .top_floor    (top_floor),
        .ground_floor (ground_floor),
        .sensor_fault (sensor_fault)
    );

    assign outs = {up_button, down_button, doors_closed, top_floor, ground_floor, sensor_fault};

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {up_raw, down_raw, door_raw, top_raw, ground_raw} = 5'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        {up_raw, down_raw, door_raw, top_raw, ground_raw} = 5'b11111;
        tick(3);
        if (outs !== 6'b000000) $display("[TB] FAIL reset_hold: got %b expected %b", outs, 6'b000000);
        else passes++;
        checks++;
        do_reset();
        tick(8);
        if (outs !== 6'b000000) $display("[TB] FAIL reset_idle: got %b expected %b", outs, 6'b000000);
        else passes++;
        checks++;
    endtask

    task automatic test_door();
        do_reset();
        door_raw = 1'b1;
        tick(5);
        if (outs !== 6'b000000) $display("[TB] FAIL door_edge5: got %b expected %b", outs, 6'b000000);
        else passes++;
        checks++;
        tick(1);
        if (outs !== 6'b001000) $display("[TB] FAIL door_edge6: got %b expected %b", outs, 6'b001000);
        else passes++;
        checks++;
    endtask

    task automatic test_up_latency();
        do_reset();
        up_raw = 1'b1;
        ground_raw = 1'b1;
        tick(6);
        if (outs !== 6'b000010) $display("[TB] FAIL up_edge6: got %b expected %b", outs, 6'b000010);
        else passes++;
        checks++;
        tick(1);
        if (outs !== 6'b100010) $display("[TB] FAIL up_edge7: got %b expected %b", outs, 6'b100010);
        else passes++;
        checks++;
        ground_raw = 1'b0;
        tick(8);
        if (outs !== 6'b100000) $display("[TB] FAIL up_hold: got %b expected %b", outs, 6'b100000);
        else passes++;
        checks++;
        top_raw = 1'b1;
        tick(5);
        if (outs !== 6'b100000) $display("[TB] FAIL top_edge5: got %b expected %b", outs, 6'b100000);
        else passes++;
        checks++;
        tick(1);
        if (outs !== 6'b100100) $display("[TB] FAIL top_edge6: got %b expected %b", outs, 6'b100100);
        else passes++;
        checks++;
        tick(1);
        if (outs !== 6'b000100) $display("[TB] FAIL top_clear7: got %b expected %b", outs, 6'b000100);
        else passes++;
        checks++;
    endtask

    task automatic test_glitch();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            up_raw = 1'b1;
            tick(3);
            up_raw = 1'b0;
            tick(1);
            if (outs !== 6'b000000) $display("[TB] FAIL glitch_%0d: got %b expected %b", i, outs, 6'b000000);
            else passes++;
            checks++;
        end
        tick(8);
        if (outs !== 6'b000000) $display("[TB] FAIL glitch_settle: got %b expected %b", outs, 6'b000000);
        else passes++;
        checks++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        up_raw = 1'b1;
        down_raw = 1'b1;
        tick(7);
        if (outs !== 6'b100000) $display("[TB] FAIL simul_up_wins: got %b expected %b", outs, 6'b100000);
        else passes++;
        checks++;
        down_raw = 1'b0;
        tick(8);
        down_raw = 1'b1;
        tick(8);
        if (outs !== 6'b100000) $display("[TB] FAIL down_blocked: got %b expected %b", outs, 6'b100000);
        else passes++;
        checks++;
    endtask

    task automatic test_top_priority();
        do_reset();
        top_raw = 1'b1;
        tick(8);
        up_raw = 1'b1;
        down_raw = 1'b1;
        tick(6);
        if (outs !== 6'b000100) $display("[TB] FAIL toppri_edge6: got %b expected %b", outs, 6'b000100);
        else passes++;
        checks++;
        tick(1);
        if (outs !== 6'b010100) $display("[TB] FAIL toppri_down_wins: got %b expected %b", outs, 6'b010100);
        else passes++;
        checks++;
    endtask

    task automatic test_hold_rearm();
        do_reset();
        up_raw = 1'b1;
        tick(7);
        if (outs !== 6'b100000) $display("[TB] FAIL rearm_first: got %b expected %b", outs, 6'b100000);
        else passes++;
        checks++;
        top_raw = 1'b1;
        tick(7);
        top_raw = 1'b0;
        tick(10);
        if (outs !== 6'b000000) $display("[TB] FAIL rearm_held: got %b expected %b", outs, 6'b000000);
        else passes++;
        checks++;
        up_raw = 1'b0;
        tick(8);
        up_raw = 1'b1;
        tick(7);
        if (outs !== 6'b100000) $display("[TB] FAIL rearm_second: got %b expected %b", outs, 6'b100000);
        else passes++;
        checks++;
    endtask

    task automatic test_fault();
        do_reset();
        up_raw = 1'b1;
        tick(8);
        top_raw = 1'b1;
        ground_raw = 1'b1;
        tick(6);
        if (outs !== 6'b100110) $display("[TB] FAIL fault_edge6: got %b expected %b", outs, 6'b100110);
        else passes++;
        checks++;
        tick(1);
        if (outs !== 6'b000001) $display("[TB] FAIL fault_edge7: got %b expected %b", outs, 6'b000001);
        else passes++;
        checks++;
        {up_raw, top_raw, ground_raw} = 3'b000;
        tick(8);
        up_raw = 1'b1;
        down_raw = 1'b1;
        tick(10);
        if (outs !== 6'b000001) $display("[TB] FAIL fault_sticky: got %b expected %b", outs, 6'b000001);
        else passes++;
        checks++;
        rst = 1'b1;
        #1;
        if (outs !== 6'b000000) $display("[TB] FAIL fault_reset: got %b expected %b", outs, 6'b000000);
        else passes++;
        checks++;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        down_raw = 1'b1;
        tick(4);
        rst = 1'b1;
        #1;
        if (outs !== 6'b000000) $display("[TB] FAIL rstmid_async: got %b expected %b", outs, 6'b000000);
        else passes++;
        checks++;
        tick(2);
        rst = 1'b0;
        tick(6);
        if (outs !== 6'b000000) $display("[TB] FAIL rstmid_edge6: got %b expected %b", outs, 6'b000000);
        else passes++;
        checks++;
        tick(1);
        if (outs !== 6'b010000) $display("[TB] FAIL rstmid_edge7: got %b expected %b", outs, 6'b010000);
        else passes++;
        checks++;
    endtask

    initial begin
        test_reset();
        test_door();
        test_up_latency();
        test_glitch();
        test_simultaneous();
        test_top_priority();
        test_hold_rearm();
        test_fault();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
